// File: rtl/x7seg_bin2bcd_scan.sv
// x7seg_bin2bcd_scan
// Accepts a 10-bit binary value over valid/ready, converts it to 4-digit
// packed BCD with a sequential shift-add-3 engine (10 shift cycles), and
// drives a 4-digit multiplexed common-anode 7-segment display from the last
// completed result.
// Optional feature: define X7SEG_BLANK_EN for leading-zero blanking of the
// thousands/hundreds/tens digits.
module x7seg_bin2bcd_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  bin_in,
  input  logic        bin_valid,
  output logic        bin_ready,
  output logic [15:0] bcd,
  output logic        done,
  output logic [6:0]  smg_duan,
  output logic [3:0]  smg_wei,
  output logic        dp
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [25:0]   sreg;
  logic [25:0]   sreg_adj;
  logic [3:0]    iter;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_next;

  // Active-low gfedcba pattern for one BCD nibble; non-decimal codes are dark.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    sreg_adj = sreg;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sreg[10 + 4*i +: 4] >= 4'd5) begin
        sreg_adj[10 + 4*i +: 4] = sreg[10 + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: accept, 10 shift-add-3 steps, publish result with a done pulse.
  // bin_ready is registered, so it returns high one cycle after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_ready <= 1'b1;
      bcd       <= '0;
      done      <= 1'b0;
      sreg      <= '0;
      iter      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bin_valid && bin_ready) begin
            sreg      <= {16'b0, bin_in};
            iter      <= '0;
            bin_ready <= 1'b0;
            state     <= SHIFT;
          end else begin
            bin_ready <= 1'b1;
          end
        end
        SHIFT: begin
          sreg <= {sreg_adj[24:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'd9) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd   <= sreg[25:10];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bin_ready <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Free-running scan timer; advances the digit index every SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Select the nibble for the current digit and decide whether it is blanked.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (idx)
      2'd0: digit = bcd[3:0];
      2'd1: digit = bcd[7:4];
      2'd2: digit = bcd[11:8];
      default: digit = bcd[15:12];
    endcase
`ifdef X7SEG_BLANK_EN
    case (idx)
      2'd0: blank = 1'b0;
      2'd1: blank = (bcd[15:4] == 12'd0);
      2'd2: blank = (bcd[15:8] == 8'd0);
      default: blank = (bcd[15:12] == 4'd0);
    endcase
`else
    blank = 1'b0;
`endif
    seg_next = blank ? 7'b1111111 : seg7(digit);
  end

  // Registered display outputs, one cycle behind the digit index and bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smg_wei  <= 4'b1110;
      smg_duan <= 7'b1000000;
    end else begin
      smg_wei  <= ~(4'b0001 << idx);
      smg_duan <= seg_next;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_x7seg_bin2bcd_scan.sv
// Self-checking bench for x7seg_bin2bcd_scan (SCAN_DIV=4).
module tb_x7seg_bin2bcd_scan;

  localparam int unsigned SCAN_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [9:0]  bin_in;
  logic        bin_valid;
  logic        bin_ready;
  logic [15:0] bcd;
  logic        done;
  logic [6:0]  smg_duan;
  logic [3:0]  smg_wei;
  logic        dp;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  logic [15:0] sb[$];

  typedef struct {
    logic [9:0]  v;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  x7seg_bin2bcd_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bin_in(bin_in),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .bcd(bcd),
    .done(done),
    .smg_duan(smg_duan),
    .smg_wei(smg_wei),
    .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) chk("done_unexpected", {31'b0, done}, 32'd0);
      else chk("bcd", {16'b0, bcd}, {16'b0, sb.pop_front()});
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bin_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", {31'b0, bin_ready}, 32'd1);
  endtask

  // Full conversion with cycle-exact latency checks; called at a negedge.
  task automatic convert(input logic [9:0] v, input logic [15:0] exp);
    wait_ready();
    bin_in    = v;
    bin_valid = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    @(negedge clk);
    bin_valid = 1'b0;
    bin_in    = 10'($urandom);
    chk("ready_low", {31'b0, bin_ready}, 32'd0);
    chk("done_n0", {31'b0, done}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("done_early", {31'b0, done}, 32'd0);
      chk("ready_busy", {31'b0, bin_ready}, 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("ready_n11", {31'b0, bin_ready}, 32'd0);
    @(negedge clk);
    chk("done_width", {31'b0, done}, 32'd0);
    chk("ready_n12", {31'b0, bin_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit found;
    logic [3:0] prev;
    logic [3:0] exp_wei[4];
    logic [6:0] exp_duan[4];

    tbl[0]  = '{10'd9,    16'h0009};
    tbl[1]  = '{10'd10,   16'h0010};
    tbl[2]  = '{10'd99,   16'h0099};
    tbl[3]  = '{10'd100,  16'h0100};
    tbl[4]  = '{10'd255,  16'h0255};
    tbl[5]  = '{10'd512,  16'h0512};
    tbl[6]  = '{10'd777,  16'h0777};
    tbl[7]  = '{10'd1000, 16'h1000};
    tbl[8]  = '{10'd1001, 16'h1001};
    tbl[9]  = '{10'd1019, 16'h1019};
    tbl[10] = '{10'd1,    16'h0001};
    tbl[11] = '{10'd888,  16'h0888};

    rst_n     = 1'b0;
    bin_valid = 1'b0;
    bin_in    = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, bin_ready}, 32'd1);
    chk("rst_bcd", {16'b0, bcd}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_wei", {28'b0, smg_wei}, 32'b1110);
    chk("rst_duan", {25'b0, smg_duan}, 32'b1000000);
    chk("rst_dp", {31'b0, dp}, 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", {31'b0, bin_ready}, 32'd1);
    chk("idle_bcd", {16'b0, bcd}, 32'h0);
    chk("idle_done", {31'b0, done}, 32'd0);

    // Basic conversion with latency check
    convert(10'd60, 16'h0060);

    // Back-to-back max then zero
    d0 = done_seen;
    convert(10'd1023, 16'h1023);
    convert(10'd0, 16'h0000);
    chk("b2b_done_count", done_seen - d0, 32'd2);

    // Valid while busy must be ignored
    d0 = done_seen;
    wait_ready();
    bin_in    = 10'd999;
    bin_valid = 1'b1;
    @(posedge clk);
    sb.push_back(16'h0999);
    @(negedge clk);
    bin_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bin_in    = 10'd5;
    bin_valid = 1'b1;
    repeat (6) @(negedge clk);
    bin_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("ign_ready", {31'b0, bin_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("ign_done_count", done_seen - d0, 32'd1);
    chk("ign_bcd", {16'b0, bcd}, 32'h0999);
    convert(10'd5, 16'h0005);

    // Table-driven conversions
    for (int i = 0; i < 12; i++) convert(tbl[i].v, tbl[i].exp);

    // Reset during conversion aborts it
    wait_ready();
    bin_in    = 10'd500;
    bin_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'b0, bin_ready}, 32'd1);
    chk("abort_bcd", {16'b0, bcd}, 32'h0);
    chk("abort_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 32'd0);
    chk("abort_bcd_hold", {16'b0, bcd}, 32'h0);
    convert(10'd500, 16'h0500);

    // Display scan of 0123
    convert(10'd123, 16'h0123);
    exp_wei[0]  = 4'b1110; exp_duan[0] = 7'b0110000;
    exp_wei[1]  = 4'b1101; exp_duan[1] = 7'b0100100;
    exp_wei[2]  = 4'b1011; exp_duan[2] = 7'b1111001;
    exp_wei[3]  = 4'b0111;
`ifdef X7SEG_BLANK_EN
    exp_duan[3] = 7'b1111111;
`else
    exp_duan[3] = 7'b1000000;
`endif
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev = smg_wei;
      @(negedge clk);
      if (prev == 4'b0111 && smg_wei == 4'b1110) begin
        found = 1'b1;
        break;
      end
    end
    chk("scan_sync", {31'b0, found}, 32'd1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        chk("scan_wei", {28'b0, smg_wei}, {28'b0, exp_wei[d]});
        chk("scan_duan", {25'b0, smg_duan}, {25'b0, exp_duan[d]});
        @(negedge clk);
      end
    end
    chk("scan_dp", {31'b0, dp}, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
